// File: rtl/burst_write_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : burst_write_feeder_if
// Purpose  : Bundles the host configuration, the inbound word stream and the
//            burst-writer control/data handshake of burst_write_feeder.
// Ports    : cfg_*  - host transfer request / status
//            st_*   - inbound word stream (valid/ready)
//            ctrl_* - per-burst control and write data toward the writer
// Modports : master - the feeder (drives cfg status, st_ready, ctrl_* outputs)
//            slave  - the environment (host, stream source and writer)
// Revision : 1.0 - initial release
// ============================================================================
interface burst_write_feeder_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BURST_WIDTH   = 4
);

  // Host configuration
  logic                     cfg_start;
  logic [ADDRESS_WIDTH-1:0] cfg_baseaddress;
  logic [31:0]              cfg_length;
  logic                     cfg_busy;
  logic                     cfg_done;

  // Inbound stream
  logic                     st_valid;
  logic [DATA_WIDTH-1:0]    st_data;
  logic                     st_ready;

  // Burst writer control and data
  logic                     ctrl_start;
  logic [ADDRESS_WIDTH-1:0] ctrl_baseaddress;
  logic [BURST_WIDTH-1:0]   ctrl_burstcount;
  logic                     ctrl_busy;
  logic                     ctrl_write;
  logic [DATA_WIDTH-1:0]    ctrl_writedata;
  logic                     ctrl_dataack;

  modport master (
    input  cfg_start, cfg_baseaddress, cfg_length,
    output cfg_busy, cfg_done,
    input  st_valid, st_data,
    output st_ready,
    output ctrl_start, ctrl_baseaddress, ctrl_burstcount,
    input  ctrl_busy,
    output ctrl_write, ctrl_writedata,
    input  ctrl_dataack
  );

  modport slave (
    output cfg_start, cfg_baseaddress, cfg_length,
    input  cfg_busy, cfg_done,
    output st_valid, st_data,
    input  st_ready,
    input  ctrl_start, ctrl_baseaddress, ctrl_burstcount,
    output ctrl_busy,
    input  ctrl_write, ctrl_writedata,
    output ctrl_dataack
  );

endinterface
`default_nettype wire

// File: rtl/burst_write_feeder.sv
`default_nettype none
// ============================================================================
// Module   : burst_write_feeder
// Purpose  : Buffers an inbound word stream in a show-ahead FIFO and splits a
//            host-configured transfer of N words into writer bursts of at
//            most BURST_COUNT words, presenting one write word per beat and
//            pulsing cfg_done once the whole transfer has been handed over.
// Ports    : clk   - single clock, rising edge
//            reset - asynchronous, active-high
//            bus   - burst_write_feeder_if.master
//                    cfg_start/cfg_baseaddress/cfg_length in, cfg_busy/cfg_done out
//                    st_valid/st_data in, st_ready out
//                    ctrl_start/ctrl_baseaddress/ctrl_burstcount out (registered)
//                    ctrl_busy in, ctrl_write/ctrl_writedata out, ctrl_dataack in
// Revision : 1.0 - initial release
// ============================================================================
module burst_write_feeder #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BURST_COUNT     = 8,
  parameter int BURST_WIDTH     = 4,
  parameter int FIFO_DEPTH      = 32,
  parameter int FIFO_DEPTH_LOG2 = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  burst_write_feeder_if.master bus
);

  localparam int COUNT_WIDTH = FIFO_DEPTH_LOG2 + 1;
  localparam logic [COUNT_WIDTH-1:0]   FULL_COUNT = COUNT_WIDTH'(FIFO_DEPTH);
  localparam logic [BURST_WIDTH-1:0]   MAX_BURST  = BURST_WIDTH'(BURST_COUNT);
  localparam logic [ADDRESS_WIDTH-1:0] WORD_BYTES = ADDRESS_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    START     = 3'd2,
    BURST     = 3'd3,
    WAIT_IDLE = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t state;

  // --------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]      mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [COUNT_WIDTH-1:0]     fifo_count;

  // Transfer bookkeeping
  logic [ADDRESS_WIDTH-1:0]   cur_addr;
  logic [31:0]                remaining;
  logic [BURST_WIDTH-1:0]     beats;

  // Registered writer-facing outputs
  logic                       start_q;
  logic                       done_q;
  logic [ADDRESS_WIDTH-1:0]   base_q;
  logic [BURST_WIDTH-1:0]     count_q;

  // Decoded control
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;
  logic                       write_avail;
  logic                       data_ready;
  logic                       last_beat;
  logic [BURST_WIDTH-1:0]     burst_len;
  logic [BURST_WIDTH-1:0]     beats_next;

  assign fifo_full  = (fifo_count == FULL_COUNT);
  assign fifo_empty = (fifo_count == '0);

  // st_ready depends only on the registered count, so no input feeds it.
  assign push = bus.st_valid && !fifo_full;
  // An ack while no write word is offered is simply ignored.
  assign pop  = bus.ctrl_dataack && write_avail;

  // remaining only changes at the last pop of a burst, so burst_len is
  // stable for the whole burst it describes.
  assign burst_len = (remaining < 32'(BURST_COUNT)) ? remaining[BURST_WIDTH-1:0]
                                                    : MAX_BURST;

  assign write_avail = (state == BURST) && (beats < burst_len);

  // Wait for the full burst to be buffered so the writer never stalls on data.
  assign data_ready  = (32'(fifo_count) >= 32'(burst_len));

  assign beats_next  = beats + BURST_WIDTH'(1);
  assign last_beat   = (beats_next == burst_len);

  // --------------------------------------------------------------------------
  // FIFO: storage is not reset; emptiness is tracked by pointers and count.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.st_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_DEPTH_LOG2'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + COUNT_WIDTH'(1);
        2'b01:   fifo_count <= fifo_count - COUNT_WIDTH'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Transfer sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      beats     <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      base_q    <= '0;
      count_q   <= '0;
    end else begin
      // Pulse outputs default low; they are raised on the edge that enters
      // START or DONE so they are high for exactly that state's cycle.
      start_q <= 1'b0;
      done_q  <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.cfg_start) begin
            cur_addr  <= bus.cfg_baseaddress;
            remaining <= bus.cfg_length;
            if (bus.cfg_length == 32'd0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= WAIT_DATA;
            end
          end
        end

        WAIT_DATA: begin
          if (data_ready && !bus.ctrl_busy) begin
            start_q <= 1'b1;
            base_q  <= cur_addr;
            count_q <= burst_len;
            beats   <= '0;
            state   <= START;
          end
        end

        START: begin
          state <= BURST;
        end

        BURST: begin
          if (pop) begin
            beats <= beats_next;
            if (last_beat) begin
              // Address arithmetic wraps naturally at ADDRESS_WIDTH bits.
              cur_addr  <= cur_addr + (ADDRESS_WIDTH'(burst_len) * WORD_BYTES);
              remaining <= remaining - 32'(burst_len);
              state     <= WAIT_IDLE;
            end
          end
        end

        WAIT_IDLE: begin
          if (!bus.ctrl_busy) begin
            if (remaining == 32'd0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= WAIT_DATA;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.cfg_busy         = (state != IDLE);
  assign bus.cfg_done         = done_q;
  assign bus.st_ready         = !fifo_full;
  assign bus.ctrl_start       = start_q;
  assign bus.ctrl_baseaddress = base_q;
  assign bus.ctrl_burstcount  = count_q;
  assign bus.ctrl_write       = write_avail;
  // Show-ahead head word; forced to zero when empty so stale storage never
  // appears on the bus after reset.
  assign bus.ctrl_writedata   = fifo_empty ? '0 : mem[rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_burst_write_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_write_feeder
// Purpose  : Directed self-checking bench for burst_write_feeder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_write_feeder;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BC  = 8;
  localparam int BW  = 4;
  localparam int FD  = 32;
  localparam int FDL = 5;

  logic clk = 1'b0;
  logic reset;

  burst_write_feeder_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) bus ();

  burst_write_feeder #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BURST_COUNT(BC),
    .BURST_WIDTH(BW), .FIFO_DEPTH(FD), .FIFO_DEPTH_LOG2(FDL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [AW-1:0] st_addr_q[$];
  logic [BW-1:0] st_cnt_q[$];
  logic [DW-1:0] acked_q[$];
  int            done_cnt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.cfg_start       = 1'b0;
    bus.cfg_baseaddress = '0;
    bus.cfg_length      = '0;
    bus.st_valid        = 1'b0;
    bus.st_data         = '0;
    bus.ctrl_busy       = 1'b0;
    bus.ctrl_dataack    = 1'b0;
  endtask

  task automatic clear_obs();
    st_addr_q.delete();
    st_cnt_q.delete();
    acked_q.delete();
    done_cnt = 0;
  endtask

  // Called at a falling edge after inputs for the coming rising edge are set.
  task automatic record();
    if (bus.ctrl_start) begin
      st_addr_q.push_back(bus.ctrl_baseaddress);
      st_cnt_q.push_back(bus.ctrl_burstcount);
    end
    if (bus.ctrl_write && bus.ctrl_dataack) acked_q.push_back(bus.ctrl_writedata);
    if (bus.cfg_done) done_cnt++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_words(input logic [31:0] first, input int n, input int max_cycles,
                            output int pushed);
    pushed = 0;
    for (int c = 0; c < max_cycles && pushed < n; c++) begin
      @(negedge clk);
      bus.st_valid = 1'b1;
      bus.st_data  = first + pushed;
      if (bus.st_ready) pushed++;
    end
    @(negedge clk);
    bus.st_valid = 1'b0;
  endtask

  task automatic start_cfg(input logic [31:0] base, input logic [31:0] len);
    @(negedge clk);
    bus.cfg_start       = 1'b1;
    bus.cfg_baseaddress = base;
    bus.cfg_length      = len;
    @(negedge clk);
    bus.cfg_start       = 1'b0;
  endtask

  // Writer model: always acks, never busy; stops a few cycles after cfg_done.
  task automatic serve(input int max_cycles);
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      bus.ctrl_dataack = 1'b1;
      record();
      if (done_cnt > 0) break;
    end
    repeat (4) begin
      @(negedge clk);
      record();
    end
    bus.ctrl_dataack = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++; if (bus.st_ready !== 1'b1) $display("FAIL reset_st_ready: got %b want 1", bus.st_ready); else passes++;
    checks++; if (bus.cfg_busy !== 1'b0) $display("FAIL reset_cfg_busy: got %b want 0", bus.cfg_busy); else passes++;
    checks++; if (bus.cfg_done !== 1'b0) $display("FAIL reset_cfg_done: got %b want 0", bus.cfg_done); else passes++;
    checks++; if (bus.ctrl_start !== 1'b0) $display("FAIL reset_ctrl_start: got %b want 0", bus.ctrl_start); else passes++;
    checks++; if (bus.ctrl_write !== 1'b0) $display("FAIL reset_ctrl_write: got %b want 0", bus.ctrl_write); else passes++;
    checks++; if (bus.ctrl_baseaddress !== 32'h0) $display("FAIL reset_base: got %h want 0", bus.ctrl_baseaddress); else passes++;
    checks++; if (bus.ctrl_burstcount !== 4'h0) $display("FAIL reset_count: got %h want 0", bus.ctrl_burstcount); else passes++;
    checks++; if (bus.ctrl_writedata !== 32'h0) $display("FAIL reset_wdata: got %h want 0", bus.ctrl_writedata); else passes++;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.cfg_busy !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", bus.cfg_busy); else passes++;
  endtask

  task automatic test_two_bursts();
    int pushed;
    apply_reset();
    clear_obs();
    push_words(32'h0, 16, 40, pushed);
    checks++; if (pushed !== 16) $display("FAIL tb2_pushed: got %0d want 16", pushed); else passes++;
    start_cfg(32'h1000, 32'd16);
    serve(200);
    checks++; if (st_addr_q.size() !== 2) $display("FAIL tb2_nstarts: got %0d want 2", st_addr_q.size()); else passes++;
    if (st_addr_q.size() == 2) begin
      checks++; if (st_addr_q[0] !== 32'h1000) $display("FAIL tb2_addr0: got %h want 1000", st_addr_q[0]); else passes++;
      checks++; if (st_addr_q[1] !== 32'h1020) $display("FAIL tb2_addr1: got %h want 1020", st_addr_q[1]); else passes++;
      checks++; if (st_cnt_q[0] !== 4'd8) $display("FAIL tb2_cnt0: got %0d want 8", st_cnt_q[0]); else passes++;
      checks++; if (st_cnt_q[1] !== 4'd8) $display("FAIL tb2_cnt1: got %0d want 8", st_cnt_q[1]); else passes++;
    end
    checks++; if (acked_q.size() !== 16) $display("FAIL tb2_nacked: got %0d want 16", acked_q.size()); else passes++;
    for (int i = 0; i < acked_q.size(); i++) begin
      checks++; if (acked_q[i] !== 32'(i)) $display("FAIL tb2_data[%0d]: got %h want %h", i, acked_q[i], 32'(i)); else passes++;
    end
    checks++; if (done_cnt !== 1) $display("FAIL tb2_done: got %0d pulses want 1", done_cnt); else passes++;
    checks++; if (bus.cfg_busy !== 1'b0) $display("FAIL tb2_busy_end: got %b want 0", bus.cfg_busy); else passes++;
  endtask

  task automatic test_latency();
    int pushed;
    apply_reset();
    clear_obs();
    push_words(32'h100, 8, 20, pushed);
    @(negedge clk);                       // cycle 0
    bus.cfg_start = 1'b1; bus.cfg_baseaddress = 32'h2000; bus.cfg_length = 32'd8;
    @(negedge clk);                       // cycle 1
    bus.cfg_start = 1'b0;
    checks++; if (bus.cfg_busy !== 1'b1) $display("FAIL lat_busy_c1: got %b want 1", bus.cfg_busy); else passes++;
    checks++; if (bus.ctrl_start !== 1'b0) $display("FAIL lat_start_c1: got %b want 0", bus.ctrl_start); else passes++;
    @(negedge clk);                       // cycle 2
    checks++; if (bus.ctrl_start !== 1'b1) $display("FAIL lat_start_c2: got %b want 1", bus.ctrl_start); else passes++;
    checks++; if (bus.ctrl_baseaddress !== 32'h2000) $display("FAIL lat_base_c2: got %h want 2000", bus.ctrl_baseaddress); else passes++;
    checks++; if (bus.ctrl_burstcount !== 4'd8) $display("FAIL lat_cnt_c2: got %0d want 8", bus.ctrl_burstcount); else passes++;
    checks++; if (bus.ctrl_write !== 1'b0) $display("FAIL lat_write_c2: got %b want 0", bus.ctrl_write); else passes++;
    @(negedge clk);                       // cycle 3
    checks++; if (bus.ctrl_write !== 1'b1) $display("FAIL lat_write_c3: got %b want 1", bus.ctrl_write); else passes++;
    checks++; if (bus.ctrl_start !== 1'b0) $display("FAIL lat_start_c3: got %b want 0", bus.ctrl_start); else passes++;
    checks++; if (bus.ctrl_writedata !== 32'h100) $display("FAIL lat_wdata_c3: got %h want 100", bus.ctrl_writedata); else passes++;
    checks++; if (bus.ctrl_baseaddress !== 32'h2000) $display("FAIL lat_base_hold: got %h want 2000", bus.ctrl_baseaddress); else passes++;
    bus.ctrl_dataack = 1'b1;
    @(negedge clk);                       // cycle 4: head advanced after one pop
    checks++; if (bus.ctrl_writedata !== 32'h101) $display("FAIL lat_wdata_c4: got %h want 101", bus.ctrl_writedata); else passes++;
    serve(100);
    checks++; if (acked_q.size() !== 6) $display("FAIL lat_nacked: got %0d want 6", acked_q.size()); else passes++;
    if (acked_q.size() > 0) begin
      checks++; if (acked_q[0] !== 32'h102) $display("FAIL lat_first_rest: got %h want 102", acked_q[0]); else passes++;
    end
    checks++; if (done_cnt !== 1) $display("FAIL lat_done: got %0d pulses want 1", done_cnt); else passes++;
  endtask

  task automatic test_short_final();
    int pushed;
    apply_reset();
    clear_obs();
    push_words(32'hA0, 10, 30, pushed);
    start_cfg(32'h0, 32'd10);
    serve(200);
    checks++; if (st_addr_q.size() !== 2) $display("FAIL sf_nstarts: got %0d want 2", st_addr_q.size()); else passes++;
    if (st_addr_q.size() == 2) begin
      checks++; if (st_addr_q[0] !== 32'h0) $display("FAIL sf_addr0: got %h want 0", st_addr_q[0]); else passes++;
      checks++; if (st_addr_q[1] !== 32'h20) $display("FAIL sf_addr1: got %h want 20", st_addr_q[1]); else passes++;
      checks++; if (st_cnt_q[0] !== 4'd8) $display("FAIL sf_cnt0: got %0d want 8", st_cnt_q[0]); else passes++;
      checks++; if (st_cnt_q[1] !== 4'd2) $display("FAIL sf_cnt1: got %0d want 2", st_cnt_q[1]); else passes++;
    end
    checks++; if (acked_q.size() !== 10) $display("FAIL sf_nacked: got %0d want 10", acked_q.size()); else passes++;
    for (int i = 0; i < acked_q.size(); i++) begin
      checks++; if (acked_q[i] !== 32'hA0 + 32'(i)) $display("FAIL sf_data[%0d]: got %h want %h", i, acked_q[i], 32'hA0 + 32'(i)); else passes++;
    end
    checks++; if (done_cnt !== 1) $display("FAIL sf_done: got %0d pulses want 1", done_cnt); else passes++;
  endtask

  task automatic test_fifo_full();
    int pushed;
    int pushed2;
    apply_reset();
    clear_obs();
    push_words(32'h0, 40, 40, pushed);
    checks++; if (pushed !== 32) $display("FAIL ff_accepted: got %0d want 32", pushed); else passes++;
    checks++; if (bus.st_ready !== 1'b0) $display("FAIL ff_ready_full: got %b want 0", bus.st_ready); else passes++;
    start_cfg(32'h0, 32'd40);
    fork
      push_words(32'd32, 8, 300, pushed2);
      serve(400);
    join
    checks++; if (pushed2 !== 8) $display("FAIL ff_rest_pushed: got %0d want 8", pushed2); else passes++;
    checks++; if (bus.st_ready !== 1'b1) $display("FAIL ff_ready_after: got %b want 1", bus.st_ready); else passes++;
    checks++; if (st_addr_q.size() !== 5) $display("FAIL ff_nstarts: got %0d want 5", st_addr_q.size()); else passes++;
    if (st_addr_q.size() == 5) begin
      checks++; if (st_addr_q[4] !== 32'h80) $display("FAIL ff_addr4: got %h want 80", st_addr_q[4]); else passes++;
    end
    checks++; if (acked_q.size() !== 40) $display("FAIL ff_nacked: got %0d want 40", acked_q.size()); else passes++;
    for (int i = 0; i < acked_q.size(); i++) begin
      checks++; if (acked_q[i] !== 32'(i)) $display("FAIL ff_data[%0d]: got %h want %h", i, acked_q[i], 32'(i)); else passes++;
    end
    checks++; if (done_cnt !== 1) $display("FAIL ff_done: got %0d pulses want 1", done_cnt); else passes++;
  endtask

  task automatic test_busy_hold();
    int pushed;
    apply_reset();
    clear_obs();
    push_words(32'h200, 16, 40, pushed);
    start_cfg(32'h4000, 32'd16);
    for (int c = 0; c < 20 && st_addr_q.size() == 0; c++) begin
      @(negedge clk);
      record();
    end
    bus.ctrl_busy    = 1'b1;
    bus.ctrl_dataack = 1'b1;
    for (int c = 0; c < 40 && acked_q.size() < 8; c++) begin
      @(negedge clk);
      record();
    end
    checks++; if (acked_q.size() !== 8) $display("FAIL bh_first_burst: got %0d beats want 8", acked_q.size()); else passes++;
    // Writer stays busy; a stray cfg_start arrives meanwhile.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.cfg_start       = (c == 3);
      bus.cfg_baseaddress = 32'h9990;
      bus.cfg_length      = 32'd3;
      record();
    end
    bus.cfg_start = 1'b0;
    checks++; if (st_addr_q.size() !== 1) $display("FAIL bh_no_start: got %0d starts want 1", st_addr_q.size()); else passes++;
    checks++; if (bus.cfg_busy !== 1'b1) $display("FAIL bh_cfg_busy: got %b want 1", bus.cfg_busy); else passes++;
    checks++; if (bus.ctrl_write !== 1'b0) $display("FAIL bh_write_idle: got %b want 0", bus.ctrl_write); else passes++;
    bus.ctrl_busy = 1'b0;
    serve(200);
    checks++; if (st_addr_q.size() !== 2) $display("FAIL bh_nstarts: got %0d want 2", st_addr_q.size()); else passes++;
    if (st_addr_q.size() == 2) begin
      checks++; if (st_addr_q[1] !== 32'h4020) $display("FAIL bh_addr1: got %h want 4020", st_addr_q[1]); else passes++;
      checks++; if (st_cnt_q[1] !== 4'd8) $display("FAIL bh_cnt1: got %0d want 8", st_cnt_q[1]); else passes++;
    end
    checks++; if (acked_q.size() !== 16) $display("FAIL bh_nacked: got %0d want 16", acked_q.size()); else passes++;
    for (int i = 0; i < acked_q.size(); i++) begin
      checks++; if (acked_q[i] !== 32'h200 + 32'(i)) $display("FAIL bh_data[%0d]: got %h want %h", i, acked_q[i], 32'h200 + 32'(i)); else passes++;
    end
    checks++; if (done_cnt !== 1) $display("FAIL bh_done: got %0d pulses want 1", done_cnt); else passes++;
  endtask

  task automatic test_zero_and_wrap();
    int pushed;
    apply_reset();
    clear_obs();
    @(negedge clk);
    bus.cfg_start = 1'b1; bus.cfg_baseaddress = 32'h55; bus.cfg_length = 32'd0;
    @(negedge clk);
    bus.cfg_start = 1'b0;
    record();
    checks++; if (bus.cfg_done !== 1'b1) $display("FAIL zl_done_c1: got %b want 1", bus.cfg_done); else passes++;
    checks++; if (bus.ctrl_start !== 1'b0) $display("FAIL zl_start_c1: got %b want 0", bus.ctrl_start); else passes++;
    @(negedge clk);
    record();
    checks++; if (bus.cfg_done !== 1'b0) $display("FAIL zl_done_c2: got %b want 0", bus.cfg_done); else passes++;
    checks++; if (bus.cfg_busy !== 1'b0) $display("FAIL zl_busy_c2: got %b want 0", bus.cfg_busy); else passes++;
    repeat (3) begin
      @(negedge clk);
      record();
    end
    checks++; if (st_addr_q.size() !== 0) $display("FAIL zl_nstarts: got %0d want 0", st_addr_q.size()); else passes++;
    checks++; if (done_cnt !== 1) $display("FAIL zl_done_cnt: got %0d want 1", done_cnt); else passes++;

    clear_obs();
    push_words(32'h500, 16, 40, pushed);
    start_cfg(32'hFFFF_FFF0, 32'd16);
    serve(200);
    checks++; if (st_addr_q.size() !== 2) $display("FAIL wr_nstarts: got %0d want 2", st_addr_q.size()); else passes++;
    if (st_addr_q.size() == 2) begin
      checks++; if (st_addr_q[0] !== 32'hFFFF_FFF0) $display("FAIL wr_addr0: got %h want fffffff0", st_addr_q[0]); else passes++;
      checks++; if (st_addr_q[1] !== 32'h0000_0010) $display("FAIL wr_addr1: got %h want 00000010", st_addr_q[1]); else passes++;
    end
    checks++; if (acked_q.size() !== 16) $display("FAIL wr_nacked: got %0d want 16", acked_q.size()); else passes++;
    checks++; if (done_cnt !== 1) $display("FAIL wr_done: got %0d pulses want 1", done_cnt); else passes++;
  endtask

  task automatic test_reset_mid_burst();
    int pushed;
    apply_reset();
    clear_obs();
    push_words(32'h300, 8, 20, pushed);
    start_cfg(32'h600, 32'd8);
    bus.ctrl_dataack = 1'b1;
    for (int c = 0; c < 30 && acked_q.size() < 2; c++) begin
      @(negedge clk);
      record();
    end
    @(negedge clk);                       // third beat is on the bus
    checks++; if (bus.ctrl_writedata !== 32'h302) $display("FAIL rm_beat3: got %h want 302", bus.ctrl_writedata); else passes++;
    bus.ctrl_dataack = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (bus.st_ready !== 1'b1) $display("FAIL rm_st_ready: got %b want 1", bus.st_ready); else passes++;
    checks++; if (bus.cfg_busy !== 1'b0) $display("FAIL rm_cfg_busy: got %b want 0", bus.cfg_busy); else passes++;
    checks++; if (bus.ctrl_write !== 1'b0) $display("FAIL rm_write: got %b want 0", bus.ctrl_write); else passes++;
    checks++; if (bus.ctrl_writedata !== 32'h0) $display("FAIL rm_wdata: got %h want 0", bus.ctrl_writedata); else passes++;
    checks++; if (bus.ctrl_baseaddress !== 32'h0) $display("FAIL rm_base: got %h want 0", bus.ctrl_baseaddress); else passes++;
    checks++; if (bus.ctrl_burstcount !== 4'h0) $display("FAIL rm_count: got %h want 0", bus.ctrl_burstcount); else passes++;
    @(negedge clk);
    reset = 1'b0;
    clear_obs();
    push_words(32'h400, 8, 20, pushed);
    start_cfg(32'h800, 32'd8);
    serve(200);
    checks++; if (st_addr_q.size() !== 1) $display("FAIL rm_nstarts: got %0d want 1", st_addr_q.size()); else passes++;
    if (st_addr_q.size() == 1) begin
      checks++; if (st_addr_q[0] !== 32'h800) $display("FAIL rm_addr0: got %h want 800", st_addr_q[0]); else passes++;
    end
    checks++; if (acked_q.size() !== 8) $display("FAIL rm_nacked: got %0d want 8", acked_q.size()); else passes++;
    for (int i = 0; i < acked_q.size(); i++) begin
      checks++; if (acked_q[i] !== 32'h400 + 32'(i)) $display("FAIL rm_data[%0d]: got %h want %h", i, acked_q[i], 32'h400 + 32'(i)); else passes++;
    end
    checks++; if (done_cnt !== 1) $display("FAIL rm_done: got %0d pulses want 1", done_cnt); else passes++;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_two_bursts();
    test_latency();
    test_short_final();
    test_fifo_full();
    test_busy_hold();
    test_zero_and_wrap();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
